// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller sharing one full-adder cell over WIDTH cycles.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.

module serial_add_ctrl_ha (
  input  logic x_i,
  input  logic y_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = x_i ^ y_i;
  assign c_o = x_i & y_i;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, s_q, sum_q, s_d;
  logic [CW-1:0]    cnt_q;
  logic             c_q, busy_q, done_q, cout_q;
  logic             p_bit, g0_bit, g1_bit, s_bit, carry_d, last_bit;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q;
`endif

  serial_add_ctrl_ha u_ha0 (.x_i(a_q[0]), .y_i(b_q[0]), .s_o(p_bit), .c_o(g0_bit));
  serial_add_ctrl_ha u_ha1 (.x_i(p_bit),  .y_i(c_q),    .s_o(s_bit), .c_o(g1_bit));

  assign carry_d  = g0_bit | g1_bit;
  // New sum bit enters at the MSB; shift form keeps WIDTH=1 legal.
  assign s_d      = (s_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= cin;
            cnt_q   <= '0;
            s_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q <= s_d;
          c_q <= carry_d;
          a_q <= a_q >> 1;
          b_q <= b_q >> 1;
          if (last_bit) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= s_d;
            cout_q  <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
            // c_q here is the carry into the MSB.
            ovf_q   <= c_q ^ carry_d;
`endif
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed and random checks of serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;
  logic       start1, a1, b1, cin1;
  logic       busy1, done1, sum1, cout1;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf, ovf1;
`endif

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issues one op, returns edges from start edge to done (0 on timeout).
  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic cv, output int lat);
    a = av; b = bv; cin = cv; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat, ndone, prev;
    logic [7:0] sum_seen;
    logic [1:0] exp1;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum",  32'(sum),  32'd0);
    chk("reset_cout", 32'(cout), 32'd0);

    // 5A + 33
    a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_after_start", 32'(busy), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("t1_latency", 32'(lat), 32'd8);
    chk("t1_busy_at_done", 32'(busy), 32'd0);
    chk("t1_sum",  32'(sum),  32'h8D);
    chk("t1_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
    chk("t1_ovf", 32'(ovf), 32'd1);
`endif
    tick();
    chk("t1_done_one_cycle", 32'(done), 32'd0);
    chk("t1_sum_held", 32'(sum), 32'h8D);

    run_op(8'hFF, 8'h01, 1'b0, lat);
    chk("t2a_latency", 32'(lat), 32'd8);
    chk("t2a_sum",  32'(sum),  32'h00);
    chk("t2a_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
    chk("t2a_ovf", 32'(ovf), 32'd0);
`endif
    tick();
    run_op(8'hFF, 8'hFF, 1'b1, lat);
    chk("t2b_sum",  32'(sum),  32'hFF);
    chk("t2b_cout", 32'(cout), 32'd1);
`ifdef SERIAL_ADD_OVF_EN
    chk("t2b_ovf", 32'(ovf), 32'd0);
`endif
    tick();

    // start during RUN is ignored
    a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    a = 8'h01; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; sum_seen = '0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) begin
        ndone++;
        sum_seen = sum;
      end
    end
    chk("t3_single_done", 32'(ndone), 32'd1);
    chk("t3_sum", 32'(sum_seen), 32'h8D);

    // reset mid-RUN aborts
    a = 8'h5A; b = 8'h33; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_done", 32'(done), 32'd0);
    chk("t4_sum",  32'(sum),  32'd0);
    chk("t4_cout", 32'(cout), 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done) ndone++;
    end
    chk("t4_no_done_after_abort", 32'(ndone), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, lat);
    chk("t4_fresh_latency", 32'(lat), 32'd8);
    chk("t4_fresh_sum", 32'(sum), 32'h30);
    tick();

    // start held high: one op every 10 cycles
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    ndone = 0; prev = -1;
    for (int k = 0; k < 45; k++) begin
      tick();
      if (done) begin
        ndone++;
        chk("t5_sum", 32'(sum), 32'h03);
        if (prev >= 0) chk("t5_period", 32'(k - prev), 32'd10);
        prev = k;
      end
    end
    chk("t5_pulse_count", 32'(ndone), 32'd4);
    start = 1'b0;
    for (int k = 0; k < 12; k++) tick();

    // WIDTH=1 instance
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("t6_busy", 32'(busy1), 32'd1);
    chk("t6_done_early", 32'(done1), 32'd0);
    tick();
    chk("t6_busy_end", 32'(busy1), 32'd0);
    chk("t6_done", 32'(done1), 32'd1);
    chk("t6_sum",  32'(sum1),  32'd1);
    chk("t6_cout", 32'(cout1), 32'd1);
    tick();
    for (int n = 0; n < 1000; n++) begin
      a1 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      cin1 = 1'($urandom_range(0, 1));
      exp1 = 2'(a1) + 2'(b1) + 2'(cin1);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      chk("t6_rand", {29'd0, done1, cout1, sum1}, {29'd0, 1'b1, exp1});
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
